posit_quire_accum: RTL and testbench

- Downstream consumer of the denormalized posit multiplier.
- Takes product beats (fraction, scale, sign, NaR, zero) and aligns each onto a fixed-point quire.
- Accumulates a window of beats delimited by sow_i/eow_i. Emits one exact quire result per window over the same rts/rtr handshake.
- Feeds the quire-to-posit normalize/round stage.

---
 rtl/posit_defines_pkg.sv | 39 +++
 rtl/posit_quire_accum_align.sv | 39 +++
 rtl/posit_quire_accum.sv | 186 ++++++++++++++++++
 tb/tb_posit_quire_accum.sv | 352 +++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/posit_defines_pkg.sv
// Shared width helpers and the accumulator state type for the posit datapath.
// A product arrives in denormalized form: a hidden one, FO fraction bits and a
// signed scale. The quire is a fixed-point register that holds every product
// exactly, plus carry headroom for long accumulations.
package posit_defines;

  // Largest regime-derived scale magnitude of a single posit.
  function automatic int get_max_scale(input int w, input int es);
    return (w - 2) << es;
  endfunction

  // Quire width: carry headroom, both product halves of the scale range, and
  // the integer bits of the widest product.
  function automatic int get_quire_width(input int w, input int es, input int carry);
    return carry + 4 * get_max_scale(w, es) + 2;
  endfunction

  // Fraction width with the hidden bit excluded. With amult set, the width is
  // that of a full multiplier product (two hidden-bit mantissas multiplied,
  // one hidden bit dropped); otherwise it is a single posit fraction.
  function automatic int get_fraction_width(input int w, input int es, input int amult);
    int fs;
    fs = w - 3 - es;
    return (amult != 0) ? 2 * (fs + 1) - 1 : fs;
  endfunction

  // Signed scale width able to hold the full product scale range.
  function automatic int get_scale_width(input int w, input int es, input int amult);
    int mx;
    mx = (amult != 0) ? 2 * get_max_scale(w, es) + 1 : get_max_scale(w, es);
    return $clog2(mx + 1) + 1;
  endfunction

  typedef enum logic {
    IDLE  = 1'b0,
    ACCUM = 1'b1
  } quire_state_t;

endpackage

// File: rtl/posit_quire_accum_align.sv
// Combinational alignment of one product onto the quire grid. The product
// {1, fraction} is shifted so that its LSB lands at weight 2^-(2*MS).
// Right shifts truncate the magnitude toward zero; the sign is applied after
// truncation. A zero product always aligns to an all-zero quire value.
module posit_quire_align
  import posit_defines::*;
#(
  parameter int POSIT_WIDTH = 8,
  parameter int POSIT_ES    = 0,
  parameter int CARRY_BITS  = 6,
  localparam int MS = get_max_scale(POSIT_WIDTH, POSIT_ES),
  localparam int QW = get_quire_width(POSIT_WIDTH, POSIT_ES, CARRY_BITS),
  localparam int FO = get_fraction_width(POSIT_WIDTH, POSIT_ES, 1),
  localparam int SW = get_scale_width(POSIT_WIDTH, POSIT_ES, 1)
) (
  input  logic [FO-1:0] fraction,
  input  logic [SW-1:0] scale,
  input  logic          zero,
  input  logic          sign,
  output logic [QW-1:0] aligned
);

  logic [QW-1:0] m_ext;
  logic [QW-1:0] mag;
  int            sh;

  // Build the mantissa, shift it to quire weight, then apply the sign.
  always_comb begin
    // NOTE: every variable written here gets a value on every path first, so
    // no latch can be inferred from a missed branch.
    m_ext       = '0;
    m_ext[FO:0] = {1'b1, fraction};
    sh          = int'($signed(scale)) + 2 * MS - FO;
    mag         = (sh >= 0) ? (m_ext << sh) : (m_ext >> (-sh));
    if (zero) mag = '0;
    aligned = sign ? -mag : mag;
  end

endmodule

// File: rtl/posit_quire_accum.sv
// Posit quire accumulator: aligns product beats onto a fixed-point quire and
// sums every window delimited by sow_i/eow_i, emitting one exact result per
// window over an rts/rtr handshake.
// Pipeline: input register (with one-entry skid) -> align register -> accumulate.
// Optional macro POSIT_QUIRE_OVF_EN adds a sticky signed-overflow flag
// (overflow_o) per window; without it the accumulator wraps modulo 2^QW.
module posit_quire_accum
  import posit_defines::*;
#(
  parameter int POSIT_WIDTH = 8,
  parameter int POSIT_ES    = 0,
  parameter int CARRY_BITS  = 6,
  localparam int QW = get_quire_width(POSIT_WIDTH, POSIT_ES, CARRY_BITS),
  localparam int FO = get_fraction_width(POSIT_WIDTH, POSIT_ES, 1),
  localparam int SW = get_scale_width(POSIT_WIDTH, POSIT_ES, 1)
) (
  input  logic          clk,
  input  logic          rst_n,
  output logic          rtr_o,
  input  logic          rts_i,
  input  logic          sow_i,
  input  logic          eow_i,
  input  logic [FO-1:0] fraction_i,
  input  logic [SW-1:0] scale_i,
  input  logic          NaR_i,
  input  logic          zero_i,
  input  logic          sign_i,
  input  logic          rtr_i,
  output logic          rts_o,
  output logic [QW-1:0] quire_o,
  output logic          NaR_o,
  output logic          zero_o
`ifdef POSIT_QUIRE_OVF_EN
  ,
  output logic          overflow_o
`endif
);

  // Beat packing: {sow, eow, nar, zero, sign, scale, fraction}.
  localparam int BW = FO + SW + 5;

  logic          receive_en;
  logic          process_en;
  logic [BW-1:0] in_beat;

  logic          skid_full;
  logic [BW-1:0] skid_beat;
  logic          r0_valid;
  logic [BW-1:0] r0_beat;

  logic          r0_sow, r0_eow, r0_nar, r0_zero, r0_sign;
  logic [SW-1:0] r0_scale;
  logic [FO-1:0] r0_frac;
  logic [QW-1:0] r0_aligned;

  logic          s1_valid, s1_sow, s1_eow, s1_nar;
  logic [QW-1:0] s1_a;

  quire_state_t  state;
  logic [QW-1:0] acc;
  logic          nar_st;
  logic          start;
  logic [QW-1:0] base;
  logic [QW-1:0] sum;
  logic          nar_next;

  assign receive_en = rts_i & rtr_o;
  assign process_en = ~rts_o | rtr_i;
  assign in_beat    = {sow_i, eow_i, NaR_i, zero_i, sign_i, scale_i, fraction_i};
  assign {r0_sow, r0_eow, r0_nar, r0_zero, r0_sign, r0_scale, r0_frac} = r0_beat;

  // Registered ready: one cycle behind the stall decision, which is why the
  // skid entry exists.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    if (!rst_n) rtr_o <= 1'b0;
    else        rtr_o <= process_en;
  end

  // Input register; a beat arriving during a stall parks in the skid entry
  // and is replayed ahead of the port once the pipeline moves again.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      skid_full <= 1'b0;
      skid_beat <= '0;
      r0_valid  <= 1'b0;
      r0_beat   <= '0;
    end else if (process_en) begin
      r0_valid  <= skid_full | receive_en;
      r0_beat   <= skid_full ? skid_beat : in_beat;
      skid_full <= 1'b0;
    end else if (receive_en) begin
      skid_beat <= in_beat;
      skid_full <= 1'b1;
    end
  end

  posit_quire_align #(
    .POSIT_WIDTH (POSIT_WIDTH),
    .POSIT_ES    (POSIT_ES),
    .CARRY_BITS  (CARRY_BITS)
  ) u_align (
    .fraction (r0_frac),
    .scale    (r0_scale),
    .zero     (r0_zero),
    .sign     (r0_sign),
    .aligned  (r0_aligned)
  );

  // Stage 1: register the aligned product with its window markers.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      s1_valid <= 1'b0;
      s1_sow   <= 1'b0;
      s1_eow   <= 1'b0;
      s1_nar   <= 1'b0;
      s1_a     <= '0;
    end else if (process_en) begin
      s1_valid <= r0_valid;
      s1_sow   <= r0_sow;
      s1_eow   <= r0_eow;
      s1_nar   <= r0_nar;
      s1_a     <= r0_aligned;
    end
  end

`ifdef POSIT_QUIRE_OVF_EN
  logic ovf_st;
  logic ovf_next;
`endif

  // Stage 2 combinational: pick the window base and form the running sum.
  always_comb begin
    start    = s1_sow | (state == IDLE);
    base     = start ? '0 : acc;
    sum      = base + s1_a;
    nar_next = (start ? 1'b0 : nar_st) | s1_nar;
`ifdef POSIT_QUIRE_OVF_EN
    ovf_next = (start ? 1'b0 : ovf_st) |
               ((base[QW-1] == s1_a[QW-1]) & (sum[QW-1] != base[QW-1]));
`endif
  end

  // Stage 2: accumulate, close windows on eow and hold the result until taken.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state   <= IDLE;
      acc     <= '0;
      nar_st  <= 1'b0;
      rts_o   <= 1'b0;
      quire_o <= '0;
      NaR_o   <= 1'b0;
      zero_o  <= 1'b0;
`ifdef POSIT_QUIRE_OVF_EN
      ovf_st     <= 1'b0;
      overflow_o <= 1'b0;
`endif
    end else if (process_en) begin
      if (s1_valid && s1_eow) begin
        quire_o <= sum;
        NaR_o   <= nar_next;
        zero_o  <= (sum == '0) & ~nar_next;
        rts_o   <= 1'b1;
        acc     <= '0;
        nar_st  <= 1'b0;
        state   <= IDLE;
`ifdef POSIT_QUIRE_OVF_EN
        overflow_o <= ovf_next;
        ovf_st     <= 1'b0;
`endif
      end else begin
        if (rtr_i) rts_o <= 1'b0;
        if (s1_valid) begin
          acc    <= sum;
          nar_st <= nar_next;
          state  <= ACCUM;
`ifdef POSIT_QUIRE_OVF_EN
          ovf_st <= ovf_next;
`endif
        end
      end
    end
  end

endmodule

// File: tb/tb_posit_quire_accum.sv
// Scoreboard bench for posit_quire_accum: the driver feeds beats and a
// value-level model pushes the expected window result at each eow; an
// independent monitor pops and compares whenever a result is transferred.
module tb_posit_quire_accum;

  localparam int MS = 6;
  localparam int FO = 11;
  localparam int SW = 5;
  localparam int QW = 32;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          rtr_o;
  logic          rts_i = 1'b0;
  logic          sow_i = 1'b0;
  logic          eow_i = 1'b0;
  logic [FO-1:0] fraction_i = '0;
  logic [SW-1:0] scale_i = '0;
  logic          NaR_i = 1'b0;
  logic          zero_i = 1'b0;
  logic          sign_i = 1'b0;
  logic          rtr_i = 1'b1;
  logic          rts_o;
  logic [QW-1:0] quire_o;
  logic          NaR_o;
  logic          zero_o;
`ifdef POSIT_QUIRE_OVF_EN
  logic          overflow_o;
`endif

  posit_quire_accum dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .rtr_o      (rtr_o),
    .rts_i      (rts_i),
    .sow_i      (sow_i),
    .eow_i      (eow_i),
    .fraction_i (fraction_i),
    .scale_i    (scale_i),
    .NaR_i      (NaR_i),
    .zero_i     (zero_i),
    .sign_i     (sign_i),
    .rtr_i      (rtr_i),
    .rts_o      (rts_o),
    .quire_o    (quire_o),
    .NaR_o      (NaR_o),
    .zero_o     (zero_o)
`ifdef POSIT_QUIRE_OVF_EN
    ,
    .overflow_o (overflow_o)
`endif
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [QW-1:0] q;
    logic          nar;
    logic          zero;
    logic          ovf;
  } exp_t;

  exp_t exp_q[$];
  int   pass_cnt = 0;
  int   total_cnt = 0;

  logic [QW-1:0] last_q = '0;
  logic          last_nar = 1'b0;
  logic          last_zero = 1'b0;
  logic          last_ovf = 1'b0;
  bit            rand_rtr = 1'b0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
  endtask

  // ---------------- reference model (window-level arithmetic) ----------------
  bit     m_open = 1'b0;
  longint m_sum = 0;
  bit     m_nar = 1'b0;
  bit     m_ovf = 1'b0;

  // Real value M * 2^(scale-FO) expressed in units of 2^-(2*MS), truncated
  // toward zero in magnitude, then signed.
  function automatic longint beat_val(input bit zro, input bit sgn,
                                      input logic [FO-1:0] frac, input int scale);
    longint m, mag;
    int     e;
    if (zro) return 0;
    m   = (longint'(1) << FO) + longint'(frac);
    e   = scale + 2 * MS - FO;
    mag = (e >= 0) ? (m << e) : (m >> (-e));
    return sgn ? -mag : mag;
  endfunction

  task automatic model_beat(input bit sow, input bit eow, input bit nar, input bit zro,
                            input bit sgn, input logic [FO-1:0] frac, input int scale);
    longint exact;
    exp_t   e;
    if (sow || !m_open) begin
      m_sum = 0;
      m_nar = 1'b0;
      m_ovf = 1'b0;
    end
    exact = m_sum + beat_val(zro, sgn, frac, scale);
    if (exact > 64'sd2147483647 || exact < -64'sd2147483648) m_ovf = 1'b1;
    m_sum = longint'(int'(exact));
    m_nar = m_nar | nar;
    if (eow) begin
      e.q    = m_sum[QW-1:0];
      e.nar  = m_nar;
      e.zero = (m_sum == 0) && !m_nar;
      e.ovf  = m_ovf;
      exp_q.push_back(e);
      m_open = 1'b0;
    end else begin
      m_open = 1'b1;
    end
  endtask

  // ---------------- driver ----------------
  task automatic send(input bit sow, input bit eow, input bit nar, input bit zro,
                      input bit sgn, input logic [FO-1:0] frac, input int scale);
    int n;
    sow_i      = sow;
    eow_i      = eow;
    NaR_i      = nar;
    zero_i     = zro;
    sign_i     = sgn;
    fraction_i = frac;
    scale_i    = scale[SW-1:0];
    rts_i      = 1'b1;
    n = 0;
    @(negedge clk);
    while (!rtr_o && n < 300) begin
      n++;
      @(negedge clk);
    end
    if (!rtr_o) begin
      $display("FAIL send_timeout: got rtr_o=0 for %0d cycles expected rtr_o=1", n);
      $fatal(1, "upstream blocked");
    end
    @(posedge clk);
    model_beat(sow, eow, nar, zro, sgn, frac, scale);
    #1;
    rts_i = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic drain();
    int n;
    n = 0;
    while ((exp_q.size() != 0 || rts_o) && n < 400) begin
      @(posedge clk);
      n++;
    end
    #1;
    check("drain_pending", 64'(exp_q.size()), 64'd0);
  endtask

  // ---------------- monitor ----------------
  always @(negedge clk) begin
    if (rst_n && rts_o && rtr_i) begin
      if (exp_q.size() == 0) begin
        check("unexpected_result", 64'd1, 64'd0);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        check("quire", 64'(quire_o), 64'(e.q));
        check("nar", 64'(NaR_o), 64'(e.nar));
        check("zero", 64'(zero_o), 64'(e.zero));
`ifdef POSIT_QUIRE_OVF_EN
        check("overflow", 64'(overflow_o), 64'(e.ovf));
        last_ovf = overflow_o;
`endif
      end
      last_q    = quire_o;
      last_nar  = NaR_o;
      last_zero = zero_o;
    end
  end

  // Random downstream backpressure during the random phase.
  always @(posedge clk) begin
    if (rand_rtr) begin
      #1;
      rtr_i = ($urandom_range(0, 3) != 0);
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got no end expected end of test");
    $fatal(1, "watchdog");
  end

  // ---------------- main sequence ----------------
  initial begin
    // Reset state
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_rts_o", 64'(rts_o), 64'd0);
    check("rst_rtr_o", 64'(rtr_o), 64'd0);
    check("rst_quire", 64'(quire_o), 64'd0);
    check("rst_nar", 64'(NaR_o), 64'd0);
    check("rst_zero", 64'(zero_o), 64'd0);
    @(posedge clk);
    #1 rst_n = 1'b1;
    idle(2);
    check("rtr_after_rst", 64'(rtr_o), 64'd1);

    // 1.0 + 1.5 with latency check
    send(1, 0, 0, 0, 0, 11'h000, 0);
    send(0, 1, 0, 0, 0, 11'h400, 0);
    idle(1);
    check("lat_t1", 64'(rts_o), 64'd0);
    idle(1);
    check("lat_t2", 64'(rts_o), 64'd1);
    drain();
    check("t1_quire", 64'(last_q), 64'h0000_2800);
    check("t1_nar", 64'(last_nar), 64'd0);
    check("t1_zero", 64'(last_zero), 64'd0);

    // Single-beat windows: negative, smallest and largest scale
    send(1, 1, 0, 0, 1, 11'h000, 0);
    drain();
    check("t2_neg", 64'(last_q), 64'hFFFF_F000);
    send(1, 1, 0, 0, 0, 11'h000, -12);
    drain();
    check("t2_min", 64'(last_q), 64'h0000_0001);
    send(1, 1, 0, 0, 0, 11'h000, 12);
    drain();
    check("t2_max", 64'(last_q), 64'h0100_0000);

    // NaR in the middle of a window, then a clean window
    send(1, 0, 0, 0, 0, 11'h000, 0);
    send(0, 0, 1, 0, 0, 11'h000, 0);
    send(0, 1, 0, 0, 0, 11'h000, 0);
    drain();
    check("t3_nar", 64'(last_nar), 64'd1);
    check("t3_zero", 64'(last_zero), 64'd0);
    send(1, 1, 0, 0, 0, 11'h000, 0);
    drain();
    check("t3b_nar", 64'(last_nar), 64'd0);
    check("t3b_quire", 64'(last_q), 64'h0000_1000);

    // Cancelling sum plus a zero beat
    send(1, 0, 0, 0, 0, 11'h000, 0);
    send(0, 0, 0, 0, 1, 11'h000, 0);
    send(0, 1, 0, 1, 0, 11'h155, 3);
    drain();
    check("t4_quire", 64'(last_q), 64'd0);
    check("t4_zero", 64'(last_zero), 64'd1);

    // Downstream stall while upstream keeps streaming
    rtr_i = 1'b0;
    fork
      begin
        send(1, 1, 0, 0, 0, 11'h000, 0);
        send(1, 0, 0, 0, 0, 11'h000, 0);
        idle(1);
        send(0, 1, 0, 0, 0, 11'h000, 0);
      end
      begin
        int n;
        logic [QW-1:0] held;
        n = 0;
        @(negedge clk);
        while (!rts_o && n < 50) begin
          n++;
          @(negedge clk);
        end
        check("t5_rts_rise", 64'(rts_o), 64'd1);
        held = quire_o;
        for (int i = 0; i < 5; i++) begin
          @(negedge clk);
          check("t5_hold_quire", 64'(quire_o), 64'(held));
          check("t5_hold_rts", 64'(rts_o), 64'd1);
        end
        check("t5_rtr_low", 64'(rtr_o), 64'd0);
        @(posedge clk);
        #1 rtr_i = 1'b1;
      end
    join
    drain();
    check("t5_quire", 64'(last_q), 64'h0000_2000);

    // Restart a window with a second sow
    send(1, 0, 0, 0, 0, 11'h000, 3);
    send(1, 0, 0, 0, 0, 11'h000, 0);
    send(0, 1, 0, 0, 0, 11'h000, 0);
    drain();
    check("restart_quire", 64'(last_q), 64'h0000_2000);

`ifdef POSIT_QUIRE_OVF_EN
    for (int i = 0; i < 128; i++) send(i == 0, i == 127, 0, 0, 0, 11'h000, 12);
    drain();
    check("t6_ovf_set", 64'(last_ovf), 64'd1);
    send(1, 1, 0, 0, 0, 11'h000, 0);
    drain();
    check("t6_ovf_clr", 64'(last_ovf), 64'd0);
`endif

    // Reset in the middle of a window
    send(1, 0, 0, 0, 0, 11'h000, 0);
    send(0, 0, 0, 0, 0, 11'h000, 0);
    idle(1);
    rst_n = 1'b0;
    m_open = 1'b0;
    @(posedge clk);
    @(negedge clk);
    check("mid_rst_rts", 64'(rts_o), 64'd0);
    check("mid_rst_rtr", 64'(rtr_o), 64'd0);
    check("mid_rst_quire", 64'(quire_o), 64'd0);
    check("mid_rst_nar", 64'(NaR_o), 64'd0);
    check("mid_rst_zero", 64'(zero_o), 64'd0);
    @(posedge clk);
    #1 rst_n = 1'b1;
    send(0, 1, 0, 0, 0, 11'h000, 0);
    drain();
    check("post_rst_quire", 64'(last_q), 64'h0000_1000);

    // Randomized windows with backpressure, bubbles, missing and restarting sow
    rand_rtr = 1'b1;
    for (int w = 0; w < 60; w++) begin
      int len;
      len = $urandom_range(1, 5);
      for (int b = 0; b < len; b++) begin
        bit sow;
        sow = (b == 0) ? ($urandom_range(0, 4) != 0) : ($urandom_range(0, 9) == 0);
        send(sow, b == len - 1, $urandom_range(0, 9) == 0, $urandom_range(0, 7) == 0,
             1'($urandom_range(0, 1)), 11'($urandom_range(0, 2047)),
             int'($urandom_range(0, 24)) - 12);
        if ($urandom_range(0, 3) == 0) idle($urandom_range(1, 3));
      end
    end
    rand_rtr = 1'b0;
    @(posedge clk);
    #1 rtr_i = 1'b1;
    drain();

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
